mdio_phy_slave: RTL and testbench
=================================

# mdio_phy_slave

Clause-22 MDIO responder (PHY side) answering management frames from our MDIO master over MDC/MDIO. Decodes read and write frames addressed to `PHY_ADDR` and serves a small register file: control, status and PHY-specific status. Used as the PHY model in system simulation and as the management target in FPGA-to-FPGA links. Register contents are driven from link/speed inputs, and control settings are exported to the MAC side.

## Interface
- `PHY_ADDR`, default 5'h04: PHY address this block answers to.
- `clk`  in  1: system clock; must be ≥ 8× MDC frequency, with MDC high and low phases each ≥ 4 clk.
- `rst_n`  in  1: asynchronous, active-low reset.
- `mdc`  in  1: management clock from the master, asynchronous to `clk`.
- `mdio_i`  in  1: MDIO pad input.
- `mdio_o`  out  1: MDIO drive value; 1 whenever `mdio_oe`=0.
- `mdio_oe`  out  1: MDIO output enable, active high.
- `link_up`  in  1: link status.
- `an_done`  in  1: auto-negotiation complete.
- `speed`  in  2: resolved speed; 00 = 10M, 01 = 100M, 10 = 1000M.
- `ctrl_reg`  out  16: current register 0 contents.
- `speed_sel`  out  2: {`ctrl_reg[6]`, `ctrl_reg[13]`}.
- `soft_rst`  out  1: one-clk pulse when register 0 bit 15 is written as 1.

## Operation
- **Input sync and edge detect**
  - `mdc` and `mdio_i` pass through two-flop synchronizers.
  - A rising edge of synchronized MDC (`mdc_r`) samples the bit.
  - A falling edge (`mdc_f`) updates the drive.
- **Bit counter and FSM.** All transitions occur on `mdc_r` unless stated otherwise.
  - **HUNT**: counts consecutive 1s, saturating at 32. A 0 with count < 32 clears the count. A 0 with count = 32 goes to ST.
  - **ST**: expects 1; otherwise back to HUNT with count cleared.
  - **OP**: 2 bits. 10 = read, 01 = write, anything else goes to HUNT.
  - **PHYAD**: 5 bits, MSB first. Sets `match` = (PHYAD == `PHY_ADDR`).
  - **REGAD**: 5 bits, MSB first. On the last bit, a read snapshots the selected register into a 16-bit shift register.
  - **TA**: 2 bits; sampled values are ignored.
  - **DATA**: 16 bits, then HUNT with count cleared.
- **Read with `match`=1**
  - On the `mdc_f` after the first TA bit is sampled: `mdio_oe`=1, `mdio_o`=0.
  - On each of the next 16 `mdc_f` edges, drive data bits 15..0.
  - On the `mdc_f` after bit 0 is sampled: `mdio_oe`=0, `mdio_o`=1.
- **Frame with `match`=0**: the full frame is still counted, but nothing is driven or written.
- **Write with `match`=1**: shift in 16 bits; commit on the `mdc_r` of bit 0.
- **Register map**
  - **0x00** (RW), reset 16'h1140.
    - Writing bit 15 = 1: `soft_rst` pulses for 1 clk and the register reloads 16'h1140, so bit 15 always reads 0.
    - Otherwise, bits [14:0] take the written value.
  - **0x01** (RO): bit 5 = `an_done`, bit 3 = 1, bit 2 = `link_up`, all other bits 0.
  - **0x11** (RO): [15:14] = `speed`, bit 10 = `link_up`, all other bits 0.
  - **Other addresses**: read 16'h0000; writes are ignored.
- **Read-only register values** are captured at snapshot time, so input changes during the DATA phase do not affect the frame.

## Timing
- **Reset values**: `mdio_o`=1, `mdio_oe`=0, `ctrl_reg`=16'h1140, `speed_sel`=2'b10, `soft_rst`=0. FSM is in HUNT with count 0.
- **Latency**: pin MDC edge to `mdio_o`/`mdio_oe` change is 3 clk (2 sync + 1 register).
- **Write commit**: `ctrl_reg` updates and `soft_rst` asserts 1 clk after the `mdc_r` of data bit 0.
- **Preamble**: back-to-back frames need a fresh preamble of ≥ 32 ones. A preamble longer than 32 is accepted.
- **Reset mid-operation**: asserting `rst_n` during DATA immediately releases `mdio_oe` and aborts the frame. After release, the block waits for a full preamble.
- **Glitch immunity**: MDIO changes while MDC is high are not sampled until the next `mdc_r`.

## Test plan
- **Reset values**: reset, then read reg 0x00 at `PHY_ADDR` → `mdio_oe` asserts for TA bit 2 plus 16 bits, returning 16'h1140; `speed_sel`=10.
- **Status read**: `link_up`=1, `an_done`=1; read 0x01 → 16'h0024 | 16'h0008 = 16'h002C. Then `speed`=01, read 0x11 → 16'h4400.
- **Control write**: write 0x00 = 16'h2000 → `ctrl_reg`=16'h2000, `speed_sel`=01, no `soft_rst`. Then write 16'h9140 → exactly one `soft_rst` pulse and `ctrl_reg`=16'h1140.
- **Address mismatch**: write 16'hFFFF to PHYAD 5'h05 → `ctrl_reg` unchanged and `mdio_oe` never asserts. A following valid read still succeeds.
- **Framing errors**:
  - Preamble of 31 ones followed by a valid frame → ignored.
  - OP=11 → ignored.
  - After an OP error, a 32-one preamble plus a read → correct data returned.
- **Mid-read reset**: assert `rst_n` low at data bit 7 of a read → `mdio_oe`=0 within 1 clk. The next complete frame after release is answered correctly.

Source files
------------

// File: rtl/mdio_phy_slave.sv
// Clause-22 MDIO responder (PHY side): decodes read/write frames for PHY_ADDR
// and serves control (0x00), status (0x01) and PHY-specific status (0x11).
module mdio_phy_slave #(
    parameter logic [4:0] PHY_ADDR = 5'h04
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mdc,
    input  logic        mdio_i,
    output logic        mdio_o,
    output logic        mdio_oe,
    input  logic        link_up,
    input  logic        an_done,
    input  logic [1:0]  speed,
    output logic [15:0] ctrl_reg,
    output logic [1:0]  speed_sel,
    output logic        soft_rst
);

    typedef enum logic [2:0] {HUNT, ST, OP, PHYAD, REGAD, TA, DATA} state_t;

    localparam logic [15:0] CTRL_RESET = 16'h1140;

    logic        mdc_s1, mdc_s2, mdc_s3;
    logic        mdio_s1, mdio_s2;
    logic        mdc_r, mdc_f;

    state_t      state, state_nx;
    logic [5:0]  cnt, cnt_nx;
    logic [14:0] sh, sh_nx;
    logic        is_read, is_read_nx;
    logic        match, match_nx;
    logic [4:0]  regad, regad_nx;
    logic [15:0] rd_sh, rd_sh_nx;
    logic [4:0]  snap_addr;
    logic [15:0] snap_val;
    logic        wr_commit;
    logic [15:0] wr_word;

    assign mdc_r     = mdc_s2 & ~mdc_s3;
    assign mdc_f     = ~mdc_s2 & mdc_s3;
    assign snap_addr = {sh[3:0], mdio_s2};
    assign wr_word   = {sh, mdio_s2};
    assign speed_sel = {ctrl_reg[6], ctrl_reg[13]};

    // Two-flop synchronizers for MDC/MDIO plus a third MDC stage for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdc_s1  <= 1'b0;
            mdc_s2  <= 1'b0;
            mdc_s3  <= 1'b0;
            mdio_s1 <= 1'b1;
            mdio_s2 <= 1'b1;
        end else begin
            mdc_s1  <= mdc;
            mdc_s2  <= mdc_s1;
            mdc_s3  <= mdc_s2;
            mdio_s1 <= mdio_i;
            mdio_s2 <= mdio_s1;
        end
    end

    // Register file read mux; read-only fields are frozen into rd_sh at snapshot time
    always_comb begin
        snap_val = 16'h0000;
        case (snap_addr)
            5'h00:   snap_val = ctrl_reg;
            5'h01:   snap_val = {10'b0, an_done, 1'b0, 1'b1, link_up, 2'b00};
            5'h11:   snap_val = {speed, 3'b000, link_up, 10'b0};
            default: snap_val = 16'h0000;
        endcase
    end

    // Frame decoder state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= HUNT;
            cnt     <= 6'd0;
            sh      <= 15'd0;
            is_read <= 1'b0;
            match   <= 1'b0;
            regad   <= 5'd0;
            rd_sh   <= 16'd0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            sh      <= sh_nx;
            is_read <= is_read_nx;
            match   <= match_nx;
            regad   <= regad_nx;
            rd_sh   <= rd_sh_nx;
        end
    end

    // Next-state logic: every field advances on a synchronized MDC rising edge
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        sh_nx      = sh;
        is_read_nx = is_read;
        match_nx   = match;
        regad_nx   = regad;
        rd_sh_nx   = rd_sh;
        wr_commit  = 1'b0;
        if (mdc_r) begin
            case (state)
                HUNT: begin
                    if (mdio_s2) begin
                        if (cnt != 6'd32) cnt_nx = cnt + 6'd1;
                    end else if (cnt == 6'd32) begin
                        state_nx = ST;
                        cnt_nx   = 6'd0;
                    end else begin
                        cnt_nx = 6'd0;
                    end
                end
                ST: begin
                    cnt_nx   = 6'd0;
                    state_nx = mdio_s2 ? OP : HUNT;
                end
                OP: begin
                    sh_nx = {sh[13:0], mdio_s2};
                    if (cnt == 6'd0) begin
                        cnt_nx = 6'd1;
                    end else begin
                        cnt_nx = 6'd0;
                        if ({sh[0], mdio_s2} == 2'b10) begin
                            is_read_nx = 1'b1;
                            state_nx   = PHYAD;
                        end else if ({sh[0], mdio_s2} == 2'b01) begin
                            is_read_nx = 1'b0;
                            state_nx   = PHYAD;
                        end else begin
                            state_nx = HUNT;
                        end
                    end
                end
                PHYAD: begin
                    sh_nx = {sh[13:0], mdio_s2};
                    if (cnt == 6'd4) begin
                        match_nx = (snap_addr == PHY_ADDR);
                        cnt_nx   = 6'd0;
                        state_nx = REGAD;
                    end else begin
                        cnt_nx = cnt + 6'd1;
                    end
                end
                REGAD: begin
                    sh_nx = {sh[13:0], mdio_s2};
                    if (cnt == 6'd4) begin
                        regad_nx = snap_addr;
                        if (is_read) rd_sh_nx = snap_val;
                        cnt_nx   = 6'd0;
                        state_nx = TA;
                    end else begin
                        cnt_nx = cnt + 6'd1;
                    end
                end
                TA: begin
                    if (cnt == 6'd1) begin
                        cnt_nx   = 6'd0;
                        state_nx = DATA;
                    end else begin
                        cnt_nx = 6'd1;
                    end
                end
                DATA: begin
                    sh_nx = {sh[13:0], mdio_s2};
                    if (cnt == 6'd15) begin
                        wr_commit = !is_read && match && (regad == 5'h00);
                        cnt_nx    = 6'd0;
                        state_nx  = HUNT;
                    end else begin
                        cnt_nx = cnt + 6'd1;
                    end
                end
                default: begin
                    cnt_nx   = 6'd0;
                    state_nx = HUNT;
                end
            endcase
        end
    end

    // Control register commit; writing bit 15 reloads defaults and pulses soft_rst
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_reg <= CTRL_RESET;
            soft_rst <= 1'b0;
        end else begin
            soft_rst <= 1'b0;
            if (wr_commit) begin
                if (wr_word[15]) begin
                    ctrl_reg <= CTRL_RESET;
                    soft_rst <= 1'b1;
                end else begin
                    ctrl_reg <= {1'b0, wr_word[14:0]};
                end
            end
        end
    end

    // MDIO driver: turnaround zero, then read data MSB first, all on MDC falling edges
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdio_oe <= 1'b0;
            mdio_o  <= 1'b1;
        end else if (mdc_f) begin
            if (state == TA && cnt == 6'd1 && is_read && match) begin
                mdio_oe <= 1'b1;
                mdio_o  <= 1'b0;
            end else if (state == DATA && is_read && match) begin
                mdio_oe <= 1'b1;
                mdio_o  <= rd_sh[~cnt[3:0]];
            end else begin
                mdio_oe <= 1'b0;
                mdio_o  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mdio_phy_slave.sv
// Directed testbench for mdio_phy_slave acting as an MDIO master on MDC/MDIO.
module tb_mdio_phy_slave;

    logic        clk;
    logic        rst_n;
    logic        mdc;
    logic        mdio_i;
    logic        mdio_o;
    logic        mdio_oe;
    logic        link_up;
    logic        an_done;
    logic [1:0]  speed;
    logic [15:0] ctrl_reg;
    logic [1:0]  speed_sel;
    logic        soft_rst;

    int n_cmp = 0;
    int n_err = 0;
    int srst_cnt = 0;
    int oe_clks = 0;

    mdio_phy_slave #(.PHY_ADDR(5'h04)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mdc       (mdc),
        .mdio_i    (mdio_i),
        .mdio_o    (mdio_o),
        .mdio_oe   (mdio_oe),
        .link_up   (link_up),
        .an_done   (an_done),
        .speed     (speed),
        .ctrl_reg  (ctrl_reg),
        .speed_sel (speed_sel),
        .soft_rst  (soft_rst)
    );

    // 100 MHz system clock, posedges at 5 + 10k ns
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count soft reset pulse cycles and cycles with MDIO driven
    always @(posedge clk) begin
        if (soft_rst === 1'b1) srst_cnt++;
        if (mdio_oe === 1'b1) oe_clks++;
    end

    // One MDC period: drive during low phase, sample PHY late in low phase,
    // glitch MDIO while MDC is high
    task automatic clk_bit(input logic b, output logic o_s, output logic oe_s);
        mdio_i = b;
        #40;
        o_s  = mdio_o;
        oe_s = mdio_oe;
        #10 mdc = 1'b1;
        #30 mdio_i = ~b;
        #20 mdc = 1'b0;
    endtask

    task automatic send_bits(input logic [31:0] v, input int n);
        logic o_s, oe_s;
        for (int i = n - 1; i >= 0; i--) clk_bit(v[i], o_s, oe_s);
    endtask

    task automatic send_pre(input int n);
        logic o_s, oe_s;
        for (int i = 0; i < n; i++) clk_bit(1'b1, o_s, oe_s);
    endtask

    task automatic do_write(input int pre_n, input logic [1:0] op, input logic [4:0] phyad,
                            input logic [4:0] regad, input logic [15:0] data);
        send_pre(pre_n);
        send_bits(32'({2'b01, op, phyad, regad, 2'b10}), 16);
        send_bits(32'(data), 16);
    endtask

    task automatic do_read(input logic [4:0] phyad, input logic [4:0] regad,
                           output logic [15:0] data, output int oe_cnt, output logic ta2_ok);
        logic o_s, oe_s;
        data   = 16'h0000;
        oe_cnt = 0;
        send_pre(32);
        send_bits(32'({2'b01, 2'b10, phyad, regad}), 14);
        clk_bit(1'b1, o_s, oe_s);
        oe_cnt += int'(oe_s);
        clk_bit(1'b1, o_s, oe_s);
        oe_cnt += int'(oe_s);
        ta2_ok = (oe_s === 1'b1) && (o_s === 1'b0);
        for (int i = 15; i >= 0; i--) begin
            clk_bit(1'b1, o_s, oe_s);
            data[i] = o_s;
            oe_cnt += int'(oe_s);
        end
        clk_bit(1'b0, o_s, oe_s);
        oe_cnt += int'(oe_s);
    endtask

    task automatic test_reset();
        logic [15:0] d;
        int          oc;
        logic        ta;
        n_cmp++;
        if (mdio_o !== 1'b1 || mdio_oe !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL reset_mdio: o=%b oe=%b required o=1 oe=0", mdio_o, mdio_oe);
        end
        n_cmp++;
        if (ctrl_reg !== 16'h1140 || speed_sel !== 2'b10 || soft_rst !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL reset_regs: ctrl=%h sel=%b srst=%b required 1140/10/0",
                     ctrl_reg, speed_sel, soft_rst);
        end
        #8 rst_n = 1'b1;
        do_read(5'h04, 5'h00, d, oc, ta);
        n_cmp++;
        if (d !== 16'h1140) begin
            n_err++;
            $display("[TB] FAIL reset_read_data: got %h required 1140", d);
        end
        n_cmp++;
        if (oc !== 17 || ta !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL reset_read_oe: oe bits %0d ta2 %b required 17 / 1", oc, ta);
        end
    endtask

    task automatic test_status_read();
        logic [15:0] d;
        int          oc;
        logic        ta;
        link_up = 1'b1;
        an_done = 1'b1;
        do_read(5'h04, 5'h01, d, oc, ta);
        n_cmp++;
        if (d !== 16'h002C || oc !== 17) begin
            n_err++;
            $display("[TB] FAIL status_reg1: got %h oe %0d required 002c oe 17", d, oc);
        end
        speed = 2'b01;
        do_read(5'h04, 5'h11, d, oc, ta);
        n_cmp++;
        if (d !== 16'h4400 || oc !== 17) begin
            n_err++;
            $display("[TB] FAIL status_reg11: got %h oe %0d required 4400 oe 17", d, oc);
        end
        do_read(5'h04, 5'h05, d, oc, ta);
        n_cmp++;
        if (d !== 16'h0000 || oc !== 17) begin
            n_err++;
            $display("[TB] FAIL unmapped_read: got %h oe %0d required 0000 oe 17", d, oc);
        end
    endtask

    task automatic test_control_write();
        int s0;
        s0 = srst_cnt;
        do_write(32, 2'b01, 5'h04, 5'h00, 16'h2000);
        #20;
        n_cmp++;
        if (ctrl_reg !== 16'h2000 || speed_sel !== 2'b01 || srst_cnt != s0) begin
            n_err++;
            $display("[TB] FAIL write_2000: ctrl=%h sel=%b pulses=%0d required 2000/01/0",
                     ctrl_reg, speed_sel, srst_cnt - s0);
        end
        s0 = srst_cnt;
        do_write(32, 2'b01, 5'h04, 5'h00, 16'h9140);
        #20;
        n_cmp++;
        if (ctrl_reg !== 16'h1140 || srst_cnt - s0 != 1) begin
            n_err++;
            $display("[TB] FAIL write_9140: ctrl=%h pulses=%0d required 1140 / 1",
                     ctrl_reg, srst_cnt - s0);
        end
    endtask

    task automatic test_addr_mismatch();
        int          oe0;
        logic [15:0] d;
        int          oc;
        logic        ta;
        oe0 = oe_clks;
        do_write(32, 2'b01, 5'h05, 5'h00, 16'hFFFF);
        do_read(5'h05, 5'h00, d, oc, ta);
        n_cmp++;
        if (ctrl_reg !== 16'h1140 || oe_clks != oe0) begin
            n_err++;
            $display("[TB] FAIL mismatch_ignored: ctrl=%h oe clks=%0d required 1140 / 0",
                     ctrl_reg, oe_clks - oe0);
        end
        do_read(5'h04, 5'h00, d, oc, ta);
        n_cmp++;
        if (d !== 16'h1140 || oc !== 17) begin
            n_err++;
            $display("[TB] FAIL mismatch_followup: got %h oe %0d required 1140 oe 17", d, oc);
        end
    endtask

    task automatic test_framing_errors();
        logic [15:0] d;
        int          oc;
        logic        ta;
        send_bits(32'd0, 1);
        do_write(31, 2'b01, 5'h04, 5'h00, 16'h2000);
        #20;
        n_cmp++;
        if (ctrl_reg !== 16'h1140) begin
            n_err++;
            $display("[TB] FAIL short_preamble: ctrl=%h required 1140", ctrl_reg);
        end
        do_write(32, 2'b11, 5'h04, 5'h00, 16'h2000);
        #20;
        n_cmp++;
        if (ctrl_reg !== 16'h1140) begin
            n_err++;
            $display("[TB] FAIL bad_opcode: ctrl=%h required 1140", ctrl_reg);
        end
        do_read(5'h04, 5'h00, d, oc, ta);
        n_cmp++;
        if (d !== 16'h1140 || oc !== 17) begin
            n_err++;
            $display("[TB] FAIL after_op_error: got %h oe %0d required 1140 oe 17", d, oc);
        end
    endtask

    task automatic test_mid_read_reset();
        logic [15:0] d;
        logic [7:0]  hi;
        int          oc;
        logic        ta, o_s, oe_s;
        do_write(32, 2'b01, 5'h04, 5'h00, 16'h2000);
        #20;
        n_cmp++;
        if (ctrl_reg !== 16'h2000) begin
            n_err++;
            $display("[TB] FAIL pre_abort_write: ctrl=%h required 2000", ctrl_reg);
        end
        send_pre(32);
        send_bits(32'({2'b01, 2'b10, 5'h04, 5'h00}), 14);
        clk_bit(1'b1, o_s, oe_s);
        clk_bit(1'b1, o_s, oe_s);
        for (int i = 7; i >= 0; i--) begin
            clk_bit(1'b1, o_s, oe_s);
            hi[i] = o_s;
        end
        mdio_i = 1'b1;
        #40;
        n_cmp++;
        if (hi !== 8'h20 || mdio_oe !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL abort_partial: hi=%h oe=%b required 20 / 1", hi, mdio_oe);
        end
        rst_n = 1'b0;
        #10;
        n_cmp++;
        if (mdio_oe !== 1'b0 || mdio_o !== 1'b1 || ctrl_reg !== 16'h1140) begin
            n_err++;
            $display("[TB] FAIL abort_release: oe=%b o=%b ctrl=%h required 0/1/1140",
                     mdio_oe, mdio_o, ctrl_reg);
        end
        rst_n = 1'b1;
        #10;
        do_read(5'h04, 5'h00, d, oc, ta);
        n_cmp++;
        if (d !== 16'h1140 || oc !== 17 || ta !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL after_abort_read: got %h oe %0d ta2 %b required 1140/17/1",
                     d, oc, ta);
        end
    endtask

    // Test sequence
    initial begin
        rst_n   = 1'b0;
        mdc     = 1'b0;
        mdio_i  = 1'b1;
        link_up = 1'b0;
        an_done = 1'b0;
        speed   = 2'b10;
        #12;
        test_reset();
        test_status_read();
        test_control_write();
        test_addr_mismatch();
        test_framing_errors();
        test_mid_read_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
